// File: rtl/counter_seq_pkg.sv
// ----------------------------------------------------------------------------
// counter_seq_pkg
// Shared definitions for the counter command sequencer slice.
//   OP_*        : command opcodes carried on cmd_op
//   seq_state_t : sequencer FSM states
// ----------------------------------------------------------------------------
package counter_seq_pkg;

   // Command opcodes as they appear on cmd_op
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_WAIT = 2'b11;

   // Sequencer states; ST_NULL is the single empty cycle used for zero-length commands
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_WAIT = 3'd3,
      ST_NULL = 3'd4
   } seq_state_t;

endpackage

// File: rtl/seq_step_timer.sv
// ----------------------------------------------------------------------------
// seq_step_timer
// Loadable down-counter that times RUN and WAIT phases of the sequencer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : load the remaining-steps register with steps
//   steps      : run length to load (STEP_W bits)
//   abort      : clear the remaining-steps register
//   active     : remaining steps are non-zero
//   last       : remaining steps equal one (final timed cycle)
// ----------------------------------------------------------------------------
module seq_step_timer
   import counter_seq_pkg::*;
#(
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [STEP_W-1:0] steps,
   input  logic              abort,
   output logic              active,
   output logic              last
);

   logic [STEP_W-1:0] remaining;

   // Remaining-steps register. A start loads the full run length; while
   // active it counts down one per cycle so that it reads 1 in the final
   // timed cycle. Start wins over abort because start is only raised from
   // IDLE, where an abort has no meaning.
   always_ff @(posedge clk) begin
      if (reset) begin
         remaining <= '0;
      end else if (start) begin
         remaining <= steps;
      end else if (abort) begin
         remaining <= '0;
      end else if (active) begin
         remaining <= remaining - 1'b1;
      end
   end

   assign active = (remaining != '0);
   assign last   = (remaining == STEP_W'(1));

endmodule

// File: rtl/counter_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// counter_cmd_sequencer
// Accepts LOAD / COUNT_UP / COUNT_DOWN / WAIT commands over a valid/ready
// handshake and expands them into cycle-exact drive for a synchronous counter.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   cmd_valid / cmd_ready : command handshake
//   cmd_op                : 00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 WAIT
//   cmd_value             : value for LOAD
//   cmd_steps             : cycle count for COUNT_UP / COUNT_DOWN / WAIT
//   abort                 : terminate the command in progress
//   data_in, load, enable, up_down : registered drive toward the counter
//   busy                  : a command is in progress
//   done / aborted        : one-cycle completion / abort acknowledge pulses
// ----------------------------------------------------------------------------
module counter_cmd_sequencer
   import counter_seq_pkg::*;
#(
   parameter int N      = 4,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [N-1:0]      cmd_value,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic              abort,
   output logic [N-1:0]      data_in,
   output logic              load,
   output logic              enable,
   output logic              up_down,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   seq_state_t state;
   logic       accept;
   logic       timer_start;
   logic       timer_active;
   logic       timer_last;

   // Handshake and status decode straight from the state register
   assign cmd_ready   = (state == ST_IDLE) && !reset;
   assign busy        = (state != ST_IDLE);
   assign accept      = cmd_valid && cmd_ready;
   assign timer_start = accept && (cmd_op != OP_LOAD) && (cmd_steps != '0);

   seq_step_timer #(
      .STEP_W (STEP_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (timer_start),
      .steps  (cmd_steps),
      .abort  (abort && busy),
      .active (timer_active),
      .last   (timer_last)
   );

   // Main sequencer FSM with registered outputs. load, done and aborted are
   // pulses and default low every cycle. data_in and up_down are only
   // rewritten when a LOAD or a non-empty COUNT starts, so the counter sees
   // stable values between commands. Abort outranks normal completion, so
   // an abort in the final RUN cycle reports aborted and never done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         data_in <= '0;
         load    <= 1'b0;
         enable  <= 1'b0;
         up_down <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         load    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (cmd_op)
                     OP_LOAD: begin
                        state   <= ST_LOAD;
                        load    <= 1'b1;
                        data_in <= cmd_value;
                        enable  <= 1'b0;
                     end
                     OP_UP, OP_DOWN: begin
                        if (cmd_steps == '0) begin
                           state  <= ST_NULL;
                           enable <= 1'b0;
                        end else begin
                           state   <= ST_RUN;
                           enable  <= 1'b1;
                           up_down <= (cmd_op == OP_UP);
                        end
                     end
                     default: begin
                        state  <= (cmd_steps == '0) ? ST_NULL : ST_WAIT;
                        enable <= 1'b0;
                     end
                  endcase
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  enable  <= 1'b0;
                  aborted <= 1'b1;
               end else if (timer_last || !timer_active) begin
                  state  <= ST_IDLE;
                  enable <= 1'b0;
                  done   <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (abort) begin
                  state   <= ST_IDLE;
                  aborted <= 1'b1;
               end else if (timer_last || !timer_active) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            ST_LOAD, ST_NULL: begin
               state   <= ST_IDLE;
               enable  <= 1'b0;
               aborted <= abort;
               done    <= !abort;
            end
            default: begin
               state  <= ST_IDLE;
               enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_counter_cmd_sequencer
// Directed bench for counter_cmd_sequencer with a behavioural 4-bit counter
// attached to its drive outputs. Expected per-command results are queued when
// a command is issued and compared when the command retires.
// ----------------------------------------------------------------------------
module tb_counter_cmd_sequencer;
   import counter_seq_pkg::*;

   localparam int N      = 4;
   localparam int STEP_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [N-1:0]      cmd_value;
   logic [STEP_W-1:0] cmd_steps;
   logic              abort;
   logic [N-1:0]      data_in;
   logic              load;
   logic              enable;
   logic              up_down;
   logic              busy;
   logic              done;
   logic              aborted;

   logic [N-1:0]      count_model = '0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      tag;
      int         loads;
      int         enables;
      int         busy_cycles;
      logic       up_dir;
      logic [3:0] load_val;
      logic       done_exp;
      logic       aborted_exp;
      logic [3:0] count_exp;
   } exp_t;

   exp_t sb_q[$];

   counter_cmd_sequencer #(
      .N      (N),
      .STEP_W (STEP_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_value (cmd_value),
      .cmd_steps (cmd_steps),
      .abort     (abort),
      .data_in   (data_in),
      .load      (load),
      .enable    (enable),
      .up_down   (up_down),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Behavioural stand-in for the downstream synchronous counter
   always @(posedge clk) begin
      if (load) begin
         count_model <= data_in;
      end else if (enable) begin
         count_model <= up_down ? count_model + 4'd1 : count_model - 4'd1;
      end
   end

   // Hard time limit so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic exp_t mkExp(input string tag, input int loads, input int enables,
                                  input int busy_cycles, input logic up_dir,
                                  input logic [3:0] load_val, input logic done_exp,
                                  input logic aborted_exp, input logic [3:0] count_exp);
      exp_t e;
      e.tag         = tag;
      e.loads       = loads;
      e.enables     = enables;
      e.busy_cycles = busy_cycles;
      e.up_dir      = up_dir;
      e.load_val    = load_val;
      e.done_exp    = done_exp;
      e.aborted_exp = aborted_exp;
      e.count_exp   = count_exp;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present a command, queue its expected outcome and wait for acceptance.
   // Returns in the first cycle after the accepting edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] val,
                                input logic [7:0] steps, input bit keep_valid,
                                input exp_t e, output int waited);
      cmd_op    = op;
      cmd_value = val;
      cmd_steps = steps;
      cmd_valid = 1'b1;
      waited    = 0;
      sb_q.push_back(e);
      while (!cmd_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!cmd_ready) begin
         checkOutput({e.tag, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         if (!keep_valid) cmd_valid = 1'b0;
      end
   endtask

   // Follow a command until busy drops, optionally injecting abort or reset
   // during the Nth enable cycle, then compare against the queued outcome.
   task automatic observeCmd(input int abort_at, input int reset_at);
      exp_t e;
      int   loads = 0;
      int   enables = 0;
      int   busy_c = 0;
      int   overlap = 0;
      int   early_pulse = 0;
      int   dir_err = 0;
      int   cyc = 0;
      e = sb_q.pop_front();
      while (busy && cyc < 100) begin
         busy_c++;
         if (load) begin
            loads++;
            checkOutput({e.tag, "_data_in"}, 32'(data_in), 32'(e.load_val));
         end
         if (enable) begin
            enables++;
            if (up_down !== e.up_dir) dir_err++;
         end
         if (load && enable) overlap++;
         if (done || aborted) early_pulse++;
         if (abort_at > 0 && enables == abort_at) abort = 1'b1;
         if (reset_at > 0 && enables == reset_at) reset = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
         cyc++;
      end
      checkOutput({e.tag, "_busy_timeout"},  32'(busy),        32'd0);
      checkOutput({e.tag, "_busy_cycles"},   32'(busy_c),      32'(e.busy_cycles));
      checkOutput({e.tag, "_load_cycles"},   32'(loads),       32'(e.loads));
      checkOutput({e.tag, "_enable_cycles"}, 32'(enables),     32'(e.enables));
      checkOutput({e.tag, "_dir_errors"},    32'(dir_err),     32'd0);
      checkOutput({e.tag, "_load_enable"},   32'(overlap),     32'd0);
      checkOutput({e.tag, "_early_pulse"},   32'(early_pulse), 32'd0);
      checkOutput({e.tag, "_done"},          32'(done),        32'(e.done_exp));
      checkOutput({e.tag, "_aborted"},       32'(aborted),     32'(e.aborted_exp));
      checkOutput({e.tag, "_enable_off"},    32'(enable),      32'd0);
      checkOutput({e.tag, "_counter"},       32'(count_model), 32'(e.count_exp));
      if (reset_at > 0) begin
         checkOutput({e.tag, "_ready_in_reset"}, 32'(cmd_ready), 32'd0);
         reset = 1'b0;
         #1;
         checkOutput({e.tag, "_ready_after_reset"}, 32'(cmd_ready), 32'd1);
         @(posedge clk); #1;
         checkOutput({e.tag, "_no_pulse_after_reset"}, 32'({done, aborted}), 32'd0);
      end
   endtask

   initial begin
      int w;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_LOAD;
      cmd_value = '0;
      cmd_steps = '0;
      abort     = 1'b0;

      // Reset held for two cycles
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_outputs", 32'({load, enable, up_down, done, aborted}), 32'd0);
      checkOutput("reset_data_in", 32'(data_in), 32'd0);
      checkOutput("reset_busy",    32'(busy), 32'd0);
      checkOutput("reset_ready",   32'(cmd_ready), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("ready_after_release", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;

      // LOAD 12
      applyStimulus(OP_LOAD, 4'd12, 8'd0, 1'b0,
                    mkExp("load12", 1, 0, 1, 1'b0, 4'd12, 1'b1, 1'b0, 4'd12), w);
      observeCmd(0, 0);

      // COUNT_UP 10 from 12 wraps to 6
      applyStimulus(OP_UP, 4'd0, 8'd10, 1'b0,
                    mkExp("up10", 0, 10, 10, 1'b1, 4'd0, 1'b1, 1'b0, 4'd6), w);
      observeCmd(0, 0);

      // Back-to-back LOAD 4 then COUNT_DOWN 7 with cmd_valid held
      applyStimulus(OP_LOAD, 4'd4, 8'd0, 1'b1,
                    mkExp("b2b_load4", 1, 0, 1, 1'b0, 4'd4, 1'b1, 1'b0, 4'd4), w);
      cmd_op    = OP_DOWN;
      cmd_steps = 8'd7;
      observeCmd(0, 0);
      applyStimulus(OP_DOWN, 4'd4, 8'd7, 1'b0,
                    mkExp("b2b_down7", 0, 7, 7, 1'b0, 4'd0, 1'b1, 1'b0, 4'd13), w);
      checkOutput("b2b_accept_in_done_cycle", 32'(w), 32'd0);
      observeCmd(0, 0);

      // Zero-length commands and a short wait
      applyStimulus(OP_UP, 4'd0, 8'd0, 1'b0,
                    mkExp("up0", 0, 0, 1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd13), w);
      observeCmd(0, 0);
      applyStimulus(OP_WAIT, 4'd0, 8'd0, 1'b0,
                    mkExp("wait0", 0, 0, 1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd13), w);
      observeCmd(0, 0);
      applyStimulus(OP_WAIT, 4'd0, 8'd3, 1'b0,
                    mkExp("wait3", 0, 0, 3, 1'b0, 4'd0, 1'b1, 1'b0, 4'd13), w);
      observeCmd(0, 0);
      checkOutput("retained_data_in", 32'(data_in), 32'd4);
      checkOutput("retained_up_down", 32'(up_down), 32'd0);

      // Abort while idle is ignored: the command accepted alongside it runs
      abort = 1'b1;
      applyStimulus(OP_WAIT, 4'd0, 8'd2, 1'b0,
                    mkExp("idle_abort_wait2", 0, 0, 2, 1'b0, 4'd0, 1'b1, 1'b0, 4'd13), w);
      abort = 1'b0;
      observeCmd(0, 0);

      // COUNT_UP 20 aborted after 5 enables: 13 + 5 = 18 -> 2
      applyStimulus(OP_UP, 4'd0, 8'd20, 1'b0,
                    mkExp("up20_abort", 0, 5, 5, 1'b1, 4'd0, 1'b0, 1'b1, 4'd2), w);
      observeCmd(5, 0);

      // COUNT_UP 20 cut by reset after 5 enables: 2 + 5 = 7, no pulses
      applyStimulus(OP_UP, 4'd0, 8'd20, 1'b0,
                    mkExp("up20_reset", 0, 5, 5, 1'b1, 4'd0, 1'b0, 1'b0, 4'd7), w);
      observeCmd(0, 5);
      checkOutput("post_reset_data_in", 32'(data_in), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/counter_cmd_sequencer.md
Name: counter_cmd_sequencer

Overview:
Upstream command stage for synchronous_counter. It accepts high-level commands over a valid/ready handshake: LOAD value, COUNT_UP n steps, COUNT_DOWN n steps, and WAIT n cycles. It expands each command into cycle-exact load/data_in/enable/up_down drive toward the counter, and signals completion with a one-cycle done pulse.

Parameters:
N, 4, counter width; width of cmd_value and data_in. Must match the synchronous_counter instance.
STEP_W, 8, width of cmd_steps; maximum run length is 2^STEP_W-1 cycles.

Ports:
clk  input  1  single clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command.
cmd_op  input  2  operation: 00 LOAD, 01 COUNT_UP, 10 COUNT_DOWN, 11 WAIT.
cmd_value  input  N  load value; used by LOAD only.
cmd_steps  input  STEP_W  cycle count; used by COUNT_UP, COUNT_DOWN and WAIT.
abort  input  1  terminate the current command.
data_in  output  N  to counter data_in.
load  output  1  to counter load.
enable  output  1  to counter enable.
up_down  output  1  to counter up_down; 1 = up.
busy  output  1  command in progress.
done  output  1  one-cycle completion pulse.
aborted  output  1  one-cycle abort acknowledge.

Behaviour:
- All outputs are registered except cmd_ready and busy, which decode the state register.
- cmd_ready = (state==IDLE) && !reset. busy = (state!=IDLE).
- Reset (synchronous, active-high):
  - Next state is IDLE.
  - data_in, load, enable, up_down, done and aborted are all 0.
  - cmd_ready is 0 while reset is high and 1 in the first cycle after it is released.
  - Reset mid-command discards the command; neither done nor aborted is pulsed.
- States:
  - IDLE: waiting for a command.
  - LOAD: drives the one-cycle load pulse.
  - RUN: COUNT_UP or COUNT_DOWN in progress.
  - WAIT: timed wait with the counter disabled.
  - NULL: single empty cycle.
- Acceptance: a command is accepted at the edge where cmd_valid && cmd_ready. cmd_op, cmd_value and cmd_steps are captured at that edge. Any cmd_valid seen while busy is not accepted; the source must hold it stable.
- LOAD:
  - The cycle after acceptance: load=1, data_in=cmd_value, enable=0.
  - Next edge: IDLE with done=1.
  - The counter holds the new value during the done cycle.
- COUNT_UP/COUNT_DOWN with steps S>0:
  - The cycle after acceptance enters RUN with enable=1 and up_down=1 (UP) or 0 (DOWN).
  - enable stays high for exactly S consecutive cycles.
  - A remaining-steps register is loaded with S and decrements each RUN cycle; when it reads 1, the next state is IDLE.
  - The cycle after the last enable has enable=0 and done=1.
  - Net counter change is ±S mod 2^N; wrap-around belongs to the counter, and the sequencer does not saturate.
- WAIT with S>0: S cycles in WAIT with enable=0 and load=0, then IDLE with done=1.
- Any non-LOAD op with S=0: one NULL cycle with busy=1 and enable=0, then done=1.
- Retained outputs: up_down keeps its last value after RUN; data_in keeps the last loaded value. Both change only when a new LOAD or COUNT command is started.
- Back-to-back: cmd_ready=1 in the done cycle. A command accepted at the edge ending the done cycle starts with no bubble beyond that done cycle.
- abort:
  - abort=1 in LOAD, RUN, WAIT or NULL: next edge goes to IDLE with load=0, enable=0, aborted=1 and done=0.
  - abort in IDLE is ignored.
  - If abort coincides with the final RUN cycle, abort wins: aborted=1, no done.
- reset has priority over abort, and abort has priority over normal progression.
- load and enable are never high in the same cycle.

Decomposition:
- Package counter_seq_pkg holds:
  - op encodings OP_LOAD=2'b00, OP_UP=2'b01, OP_DOWN=2'b10, OP_WAIT=2'b11;
  - state encodings for IDLE, LOAD, RUN, WAIT and NULL.
- One sub-module, seq_step_timer. It is a STEP_W-bit loadable down-counter with ports start, steps, abort, reset, and outputs active and last. RUN and WAIT share it.
- FSM, output registers and handshake stay in counter_cmd_sequencer.

Test Plan:
- Reset: hold reset 2 cycles, then release. Required: load=enable=up_down=done=aborted=0, data_in=0, busy=0, cmd_ready=0 during reset and 1 the cycle after release.
- LOAD 4'b1100: exactly one cycle of load=1 with data_in=1100 and enable=0. done follows one cycle later; the attached synchronous_counter (N=4) reads 12.
- COUNT_UP steps=10 from 12: enable=1 and up_down=1 for exactly 10 cycles. Counter wraps to 6; done pulses once the cycle after the last enable.
- Back-to-back with cmd_valid held: LOAD 4'b0100 then COUNT_DOWN steps=7. The second command is accepted at the end of the LOAD done cycle; 7 enable cycles with up_down=0; counter ends at 13.
- Zero-length commands: COUNT_UP steps=0 and WAIT steps=0. Required: busy for 1 cycle, no enable, done 1 cycle later, counter unchanged; WAIT steps=3 gives 3 busy cycles then done.
- Abort then reset: COUNT_UP steps=20 with abort after 5 enable cycles. Required: enable drops next cycle, aborted=1, no done, counter advanced by exactly 5. Repeat with reset instead of abort: same stop, with neither aborted nor done pulsed.
